// File: rtl/spi_slave_module.sv
// SPI mode-0 MSB-first slave: oversampled pins, tx holding register, rx valid/ready.
// Define SPI_SLAVE_OVERRUN_EN for the drop-new-byte overrun policy with a sticky flag.

module spi_slave_module #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_spi_sck,
    input  logic              I_spi_cs,
    input  logic              I_spi_mosi,
    output logic              O_spi_miso,
    output logic              O_spi_miso_oe,
    input  logic [DATA_W-1:0] I_tx_data,
    input  logic              I_tx_valid,
    output logic              O_tx_ready,
    output logic [DATA_W-1:0] O_rx_data,
    output logic              O_rx_valid,
    input  logic              I_rx_ready,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic              O_rx_overrun,
    input  logic              I_ovr_clr,
`endif
    output logic              O_busy
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
    logic sck_s, cs_s, mosi_s, sck_d, cs_d;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-2:0] tx_shift;
    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic [DATA_W-1:0] tx_byte, rx_byte;
    logic tx_load, tx_shift_en, rx_shift_en, byte_done;

    // CS chain resets low so a CS already low at release never looks like a fall
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sck_sr  <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], I_spi_sck};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], I_spi_cs};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], I_spi_mosi};
            sck_d   <= sck_s;
            cs_d    <= cs_s;
        end
    end

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign tx_byte = hold_valid ? hold_data : IDLE_BYTE;
    assign rx_byte = {rx_shift, mosi_s};

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        tx_load     = 1'b0;
        tx_shift_en = 1'b0;
        rx_shift_en = 1'b0;
        byte_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cs_fall) begin
                    state_n = S_ACTIVE;
                    tx_load = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    state_n = S_IDLE;
                end else begin
                    if (sck_rise) begin
                        rx_shift_en = 1'b1;
                        byte_done   = (bit_cnt == LAST_BIT);
                    end
                    if (sck_fall) begin
                        tx_load     = (bit_cnt == '0);
                        tx_shift_en = (bit_cnt != '0);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            O_spi_miso <= 1'b0;
        end else if (state_n == S_IDLE) begin
            bit_cnt    <= '0;
            O_spi_miso <= 1'b0;
        end else begin
            if (rx_shift_en) begin
                rx_shift <= rx_byte[DATA_W-2:0];
                bit_cnt  <= bit_cnt + 1'b1;
            end
            if (tx_load)
                {O_spi_miso, tx_shift} <= tx_byte;
            else if (tx_shift_en)
                {O_spi_miso, tx_shift} <= {tx_shift, 1'b0};
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (tx_load && hold_valid) begin
            hold_valid <= 1'b0;
        end else if (I_tx_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= I_tx_data;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rx_data  <= '0;
            O_rx_valid <= 1'b0;
        end else if (byte_done) begin
            if (!O_rx_valid || I_rx_ready) begin
                O_rx_data  <= rx_byte;
                O_rx_valid <= 1'b1;
            end else begin
`ifndef SPI_SLAVE_OVERRUN_EN
                O_rx_data  <= rx_byte;
`endif
            end
        end else if (O_rx_valid && I_rx_ready) begin
            O_rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            O_rx_overrun <= 1'b0;
        else if (byte_done && O_rx_valid && !I_rx_ready)
            O_rx_overrun <= 1'b1;
        else if (I_ovr_clr)
            O_rx_overrun <= 1'b0;
    end
`endif

    assign O_tx_ready    = ~hold_valid;
    assign O_spi_miso_oe = (state == S_ACTIVE);
    assign O_busy        = (state == S_ACTIVE);

endmodule

// File: doc/spi_slave_module.md
# spi_slave_module

SPI mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit slave endpoint clocked by I_clk. It oversamples the external SCK/CS/MOSI pins and shifts received bytes into a valid/ready output. It shifts queued transmit bytes out on MISO. It sits on the far side of the link from the team's SPI master: in loopback benches, and in FPGA designs that are themselves polled by an external SPI host.

## Interface
- DATA_W, 8: frame width in bits; the only supported value is 8.
- SYNC_STAGES, 2: flip-flop depth of the pin synchronizers; minimum 2.
- IDLE_BYTE, 8'hFF: byte shifted out when no transmit byte is queued at byte start.

- I_clk  input  1  system clock. Reset I_rst_n, asynchronous, active-low; clock I_clk.
- I_rst_n  input  1  asynchronous active-low reset.
- I_spi_sck  input  1  SPI clock from the master; asynchronous to I_clk.
- I_spi_cs  input  1  chip select, active-low, asynchronous.
- I_spi_mosi  input  1  serial data from the master.
- O_spi_miso  output  1  serial data to the master.
- O_spi_miso_oe  output  1  MISO output enable; 1 while synchronized CS is low. Tristating is done at the top level.
- I_tx_data  input  8  next byte to transmit.
- I_tx_valid  input  1  I_tx_data is valid.
- O_tx_ready  output  1  the holding register is empty; a byte is accepted when I_tx_valid & O_tx_ready.
- O_rx_data  output  8  last received byte.
- O_rx_valid  output  1  O_rx_data holds an unconsumed byte.
- I_rx_ready  input  1  consumer accepts O_rx_data; the transfer happens when O_rx_valid & I_rx_ready.
- O_busy  output  1  synchronized CS is low.
- O_rx_overrun  output  1  sticky overrun flag. Present only with SPI_SLAVE_OVERRUN_EN.
- I_ovr_clr  input  1  clears O_rx_overrun. Present only with SPI_SLAVE_OVERRUN_EN.

## Operation
- SCK, CS and MOSI each pass through SYNC_STAGES flip-flops. A further register stage provides SCK/CS edge detection.
- All three pins share the same delay, so the synchronized MOSI is coherent with the detected SCK rising edge.
- State IDLE (synchronized CS high):
  - bit_cnt=0; O_spi_miso=0; O_spi_miso_oe=0.
  - SCK edges are ignored.
- IDLE -> ACTIVE on a detected CS falling edge:
  - tx_shift loads the holding register if it is full; the holding register is marked empty in the same cycle.
  - Otherwise tx_shift loads IDLE_BYTE.
  - O_spi_miso <= bit 7 of the loaded byte.
- ACTIVE, SCK rising edge:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit counter, wraps 7->0).
  - When bit_cnt==7, the byte is complete: {rx_shift[6:0], mosi_sync} is delivered to the rx stage.
- ACTIVE, SCK falling edge:
  - If bit_cnt==0 (a byte boundary was just crossed), reload tx_shift as at CS fall (holding register or IDLE_BYTE) and drive its bit 7.
  - Otherwise shift tx_shift left and drive the new bit 7.
- ACTIVE -> IDLE on a detected CS rising edge, at any bit position:
  - A partial rx byte is discarded; no O_rx_valid.
  - A partial tx byte is lost.
  - The holding register is untouched if it was not consumed.
  - bit_cnt=0.
- Tx holding register:
  - O_tx_ready = !hold_valid.
  - Load on I_tx_valid & O_tx_ready.
  - A consume and an accept in the same cycle cannot occur, because ready is low while the register is full.
- Rx stage, byte complete:
  - If O_rx_valid=0, or I_rx_ready=1 in the same cycle: O_rx_data <= new byte and O_rx_valid <= 1.
  - If O_rx_valid=1 and I_rx_ready=0: the overrun policy under Configuration applies.
- O_rx_valid clears on O_rx_valid & I_rx_ready when no new byte completes in that cycle.
- Reset values:
  - O_spi_miso=0, O_spi_miso_oe=0, O_busy=0.
  - O_rx_data=8'h00, O_rx_valid=0.
  - O_tx_ready=1 (holding register empty).
  - O_rx_overrun=0.
  - Internal state: IDLE.
- Reset asserted mid-frame returns the block to IDLE immediately. After reset release, the block waits for a fresh CS falling edge; a CS already low at release is not treated as a frame start.

## Timing
- SCK high and low phases must each be ≥4 I_clk cycles (f_SCK ≤ f_clk/8). CS-low-to-first-SCK-rise must be ≥4 I_clk cycles.
- Pin-to-detection latency: SYNC_STAGES+1 I_clk cycles; this is 3 cycles at default.
- O_spi_miso updates 1 cycle after the detected falling edge (or CS fall). Worst case is SYNC_STAGES+2 I_clk cycles after the pin edge, which is well inside the half-period.
- O_rx_valid rises 1 cycle after the detection of the 8th SCK rising edge.
- O_tx_ready rises 1 cycle after the holding register is consumed.
- Back-to-back bytes within one CS-low frame need no gap. The tx holding register must be refilled before the falling edge that follows the 8th rising edge, or IDLE_BYTE is sent.

## Configuration
- SPI_SLAVE_OVERRUN_EN defined:
  - On an overrun, the new byte is dropped and O_rx_data keeps the old byte.
  - O_rx_overrun sets (sticky) and clears on I_ovr_clr=1.
  - If set and clear occur in the same cycle, set wins.
- SPI_SLAVE_OVERRUN_EN undefined:
  - The new byte overwrites O_rx_data and O_rx_valid stays 1.
  - The O_rx_overrun and I_ovr_clr ports are absent.

## Test plan
- Reset mid-frame (CS low, 4 bits in) -> all outputs at their reset values; a subsequent clean frame is received correctly.
- Queue 8'hA5, then master sends 8'h3C at f_clk/8 -> master samples 8'hA5 on MISO; O_rx_data=8'h3C with O_rx_valid=1 one cycle after the 8th rise.
- No tx queued, master sends 8'h00 -> master reads 8'hFF.
- 3-byte frame with tx 8'h11, 8'h22, 8'h33 refilled on each O_tx_ready, I_rx_ready held 1 -> rx 3 bytes in order; master reads 11, 22, 33.
- CS released after 5 bits -> no O_rx_valid, and the queued tx byte is not re-sent. The next frame starts at bit 7 of the next queued byte or IDLE_BYTE.
- Two bytes 8'h01, 8'h02 received with I_rx_ready=0 -> with the macro, O_rx_data=8'h01 and O_rx_overrun=1 until I_ovr_clr; without it, O_rx_data=8'h02 with O_rx_valid=1.
